// File: rtl/falling_sand_pkg.sv
// Shared types and constants for the falling-sand game-state datapath.
package falling_sand_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 19;

  typedef enum logic [1:0] {
    OWNER_IDLE = 2'b00,
    OWNER_SIM  = 2'b01,
    OWNER_DRAW = 2'b10
  } owner_t;

endpackage

// File: rtl/game_state_ram_write_arbiter.sv
// Arbitrates the game-state RAM write port between the sim sequencer and the
// mouse pixel drawer: draw priority with a burst limit, same-address merge.
module game_state_ram_write_arbiter
  import falling_sand_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = 1,
  parameter int DRAW_BURST = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  sim_wr_req_i,
  input  logic [ADDR_WIDTH-1:0] sim_wr_address_i,
  input  logic [DATA_WIDTH-1:0] sim_wr_data_i,
  output logic                  sim_wr_gnt_o,
  input  logic                  draw_wr_req_i,
  input  logic [ADDR_WIDTH-1:0] draw_wr_address_i,
  input  logic [DATA_WIDTH-1:0] draw_wr_data_i,
  output logic                  draw_wr_gnt_o,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_address_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic [1:0]            owner_o,
  output logic                  sim_drop_o
);

  owner_t     owner;
  owner_t     owner_next;
  logic [7:0] burst_cnt;
  logic       merge;

  assign owner_o = owner;

  // Grants are held low while reset is asserted so every output reads 0.
  always_comb begin
    sim_wr_gnt_o  = 1'b0;
    draw_wr_gnt_o = 1'b0;
    owner_next    = OWNER_IDLE;
    merge         = 1'b0;
    if (reset_i) begin
      if (sim_wr_req_i && draw_wr_req_i) begin
        if (sim_wr_address_i == draw_wr_address_i) begin
          sim_wr_gnt_o  = 1'b1;
          draw_wr_gnt_o = 1'b1;
          merge         = 1'b1;
          owner_next    = OWNER_DRAW;
        end else if (burst_cnt >= 8'(DRAW_BURST)) begin
          sim_wr_gnt_o = 1'b1;
          owner_next   = OWNER_SIM;
        end else begin
          draw_wr_gnt_o = 1'b1;
          owner_next    = OWNER_DRAW;
        end
      end else if (sim_wr_req_i) begin
        sim_wr_gnt_o = 1'b1;
        owner_next   = OWNER_SIM;
      end else if (draw_wr_req_i) begin
        draw_wr_gnt_o = 1'b1;
        owner_next    = OWNER_DRAW;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      owner            <= OWNER_IDLE;
      burst_cnt        <= '0;
      ram_wr_en_o      <= 1'b0;
      ram_wr_address_o <= '0;
      ram_wr_data_o    <= '0;
      sim_drop_o       <= 1'b0;
    end else begin
      owner       <= owner_next;
      sim_drop_o  <= merge;
      ram_wr_en_o <= sim_wr_gnt_o | draw_wr_gnt_o;
      // On a merge the draw pixel wins the cell.
      if (draw_wr_gnt_o) begin
        ram_wr_address_o <= draw_wr_address_i;
        ram_wr_data_o    <= draw_wr_data_i;
      end else if (sim_wr_gnt_o) begin
        ram_wr_address_o <= sim_wr_address_i;
        ram_wr_data_o    <= sim_wr_data_i;
      end
      if (!sim_wr_req_i || sim_wr_gnt_o) begin
        burst_cnt <= '0;
      end else if (draw_wr_gnt_o) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_game_state_ram_write_arbiter.sv
// Directed bench for game_state_ram_write_arbiter with a write scoreboard.
module tb_game_state_ram_write_arbiter;
  import falling_sand_pkg::*;

  localparam int AW = 19;

  typedef struct {
    logic [AW-1:0] addr;
    logic          data;
    logic [1:0]    owner;
    logic          drop;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sim_req = 1'b0;
  logic [AW-1:0] sim_addr = '0;
  logic          sim_data = 1'b0;
  logic          sim_gnt;
  logic          draw_req = 1'b0;
  logic [AW-1:0] draw_addr = '0;
  logic          draw_data = 1'b0;
  logic          draw_gnt;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic          ram_data;
  logic [1:0]    owner;
  logic          sim_drop;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  wr_t           sb[$];
  logic [AW-1:0] last_addr = '0;
  logic          last_data = 1'b0;

  game_state_ram_write_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(1),
    .DRAW_BURST(4)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_n),
    .sim_wr_req_i(sim_req),
    .sim_wr_address_i(sim_addr),
    .sim_wr_data_i(sim_data),
    .sim_wr_gnt_o(sim_gnt),
    .draw_wr_req_i(draw_req),
    .draw_wr_address_i(draw_addr),
    .draw_wr_data_i(draw_data),
    .draw_wr_gnt_o(draw_gnt),
    .ram_wr_en_o(ram_en),
    .ram_wr_address_o(ram_addr),
    .ram_wr_data_o(ram_data),
    .owner_o(owner),
    .sim_drop_o(sim_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output register contents expected one cycle after a grant (or lack of one).
  task automatic check_outputs(input string tag);
    wr_t w;
    if (sb.size() > 0) begin
      w = sb.pop_front();
      chk({tag, ".en"},    32'(ram_en),   32'd1);
      chk({tag, ".addr"},  32'(ram_addr), 32'(w.addr));
      chk({tag, ".data"},  32'(ram_data), 32'(w.data));
      chk({tag, ".owner"}, 32'(owner),    32'(w.owner));
      chk({tag, ".drop"},  32'(sim_drop), 32'(w.drop));
      last_addr = w.addr;
      last_data = w.data;
    end else begin
      chk({tag, ".en"},    32'(ram_en),   32'd0);
      chk({tag, ".addr"},  32'(ram_addr), 32'(last_addr));
      chk({tag, ".data"},  32'(ram_data), 32'(last_data));
      chk({tag, ".owner"}, 32'(owner),    32'(OWNER_IDLE));
      chk({tag, ".drop"},  32'(sim_drop), 32'd0);
    end
  endtask

  // Called at posedge+1: drive, check grants, push expected write, clock, check write.
  task automatic step(input string tag,
                      input logic sr, input logic [AW-1:0] sa, input logic sd,
                      input logic dr, input logic [AW-1:0] da, input logic dd,
                      input logic esg, input logic edg);
    wr_t w;
    sim_req = sr;  sim_addr = sa;  sim_data = sd;
    draw_req = dr; draw_addr = da; draw_data = dd;
    #1;
    chk({tag, ".sim_gnt"},  32'(sim_gnt),  32'(esg));
    chk({tag, ".draw_gnt"}, 32'(draw_gnt), 32'(edg));
    if (edg) begin
      w.addr = da; w.data = dd; w.owner = OWNER_DRAW; w.drop = esg;
      sb.push_back(w);
    end else if (esg) begin
      w.addr = sa; w.data = sd; w.owner = OWNER_SIM; w.drop = 1'b0;
      sb.push_back(w);
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  localparam logic [AW-1:0] SA = 19'h00200;
  localparam logic [AW-1:0] DA = 19'h00300;

  initial begin
    // Reset held with both requesters active.
    sim_req = 1'b1;  sim_addr = 19'h00001;  sim_data = 1'b1;
    draw_req = 1'b1; draw_addr = 19'h00002; draw_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.sim_gnt",  32'(sim_gnt),  32'd0);
    chk("rst.draw_gnt", 32'(draw_gnt), 32'd0);
    check_outputs("rst");
    reset_n = 1'b1;
    step("rel", 1'b1, 19'h00001, 1'b1, 1'b1, 19'h00002, 1'b1, 1'b0, 1'b1);
    step("idle0", 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    step("simonly", 1'b1, 19'h00100, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    step("idle1", 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++)
      step("cont", 1'b1, SA, 1'b0, 1'b1, DA, 1'b1, (i % 5) == 4, (i % 5) != 4);
    step("idle2", 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    step("merge", 1'b1, 19'h12C00, 1'b0, 1'b1, 19'h12C00, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      step("postmerge", 1'b1, SA, 1'b0, 1'b1, DA, 1'b1, i == 4, i != 4);
    step("idle3", 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    step("drop.d0", 1'b1, SA, 1'b1, 1'b1, DA, 1'b0, 1'b0, 1'b1);
    step("drop.d1", 1'b1, SA, 1'b1, 1'b1, DA, 1'b0, 1'b0, 1'b1);
    step("drop.gap", 1'b0, SA, 1'b1, 1'b1, DA, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      step("drop.ret", 1'b1, SA, 1'b1, 1'b1, DA, 1'b0, i == 4, i != 4);

    // Grant, then reset lands while the write is sitting in the output register.
    sim_req = 1'b1; sim_addr = 19'h00400; sim_data = 1'b1; draw_req = 1'b0;
    #1;
    chk("midrst.sim_gnt", 32'(sim_gnt), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    sim_req = 1'b0;
    #1;
    sb.delete();
    last_addr = '0;
    last_data = 1'b0;
    check_outputs("midrst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("postrst", 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
